// File: rtl/dffram_pkg.sv
// Shared types and constants for the nibble-port DFF RAM word writer.
package dffram_pkg;

    localparam int ADDRWIDTH  = 5;
    localparam int NIBWIDTH   = 4;
    localparam int ADDR_LIMIT = 28;
    localparam int FIFO_DEPTH = 2;

    // Write-port and read-port lohi encodings are opposite polarities.
    localparam logic LOHI_WR_LO = 1'b1;
    localparam logic LOHI_RD_LO = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        WR_LO,
        WR_HI,
        VFY_LO,
        VFY_HI
    } state_t;

endpackage

// File: rtl/dffram_word_fifo.sv
// Synchronous FIFO with power-of-two depth; an extra pointer bit separates full from empty.
module dffram_word_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q;
    logic [PW:0]      rd_ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[PW-1:0]] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q[PW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

endmodule

// File: rtl/dffram_word_writer.sv
// Word-to-nibble write sequencer for the 32x8 nibble-port DFF RAM.
// Optional macro WRITER_READBACK_VERIFY_EN adds a two-cycle read-back check after each word.
module dffram_word_writer #(
    parameter int ADDRWIDTH  = dffram_pkg::ADDRWIDTH,
    parameter int NIBWIDTH   = dffram_pkg::NIBWIDTH,
    parameter int ADDR_LIMIT = dffram_pkg::ADDR_LIMIT,
    parameter int FIFO_DEPTH = dffram_pkg::FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDRWIDTH-1:0]  in_addr,
    input  logic [2*NIBWIDTH-1:0] in_data,
    output logic [ADDRWIDTH-1:0]  ram_addr,
    output logic [NIBWIDTH-1:0]   ram_wdata,
    output logic                  ram_lohi,
    output logic                  ram_wen,
    output logic                  busy,
    output logic                  addr_err
`ifdef WRITER_READBACK_VERIFY_EN
    ,
    output logic [ADDRWIDTH-1:0]  rb_addr,
    output logic                  rb_lohi,
    input  logic [NIBWIDTH-1:0]   rb_rdata,
    output logic                  vfy_err
`endif
);

    import dffram_pkg::*;

    localparam int WORDW = 2 * NIBWIDTH;
    localparam int FW    = ADDRWIDTH + WORDW;
    localparam logic [ADDRWIDTH:0] LIMIT = (ADDRWIDTH+1)'(ADDR_LIMIT);

    state_t               state_q, state_d;
    logic [ADDRWIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [WORDW-1:0]     cur_data_q, cur_data_d;
    logic [ADDRWIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [NIBWIDTH-1:0]  ram_wdata_q, ram_wdata_d;
    logic                 ram_lohi_q, ram_lohi_d;
    logic                 ram_wen_q, ram_wen_d;
    logic                 addr_err_q, addr_err_d;
`ifdef WRITER_READBACK_VERIFY_EN
    logic                 vfy_err_q, vfy_err_d;
`endif

    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FW-1:0]        fifo_rdata;
    logic [ADDRWIDTH-1:0] head_addr;
    logic [WORDW-1:0]     head_data;
    logic                 head_bad;
    logic                 take_next;

    assign in_ready  = !fifo_full && !rst;
    assign fifo_push = in_valid && in_ready;

    dffram_word_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i ({in_addr, in_data}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {head_addr, head_data} = fifo_rdata;
    assign head_bad = ({1'b0, head_addr} >= LIMIT);

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        cur_data_d  = cur_data_q;
        ram_addr_d  = '0;
        ram_wdata_d = '0;
        ram_lohi_d  = 1'b0;
        ram_wen_d   = 1'b0;
        addr_err_d  = addr_err_q;
        fifo_pop    = 1'b0;
        take_next   = 1'b0;
`ifdef WRITER_READBACK_VERIFY_EN
        vfy_err_d   = vfy_err_q;
`endif
        case (state_q)
            IDLE: take_next = 1'b1;
            WR_LO: begin
                state_d     = WR_HI;
                ram_wen_d   = 1'b1;
                ram_lohi_d  = ~LOHI_WR_LO;
                ram_wdata_d = cur_data_q[WORDW-1:NIBWIDTH];
                ram_addr_d  = cur_addr_q;
            end
`ifdef WRITER_READBACK_VERIFY_EN
            WR_HI: state_d = VFY_LO;
            VFY_LO: begin
                state_d = VFY_HI;
                if (rb_rdata != cur_data_q[NIBWIDTH-1:0]) vfy_err_d = 1'b1;
            end
            VFY_HI: begin
                take_next = 1'b1;
                if (rb_rdata != cur_data_q[WORDW-1:NIBWIDTH]) vfy_err_d = 1'b1;
            end
`else
            WR_HI: take_next = 1'b1;
`endif
            default: state_d = IDLE;
        endcase

        // A dropped out-of-range word costs one idle cycle before the next entry is looked at.
        if (take_next) begin
            state_d = IDLE;
            if (!fifo_empty) begin
                fifo_pop = 1'b1;
                if (head_bad) begin
                    addr_err_d = 1'b1;
                end else begin
                    state_d     = WR_LO;
                    cur_addr_d  = head_addr;
                    cur_data_d  = head_data;
                    ram_wen_d   = 1'b1;
                    ram_lohi_d  = LOHI_WR_LO;
                    ram_wdata_d = head_data[NIBWIDTH-1:0];
                    ram_addr_d  = head_addr;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            cur_data_q  <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_lohi_q  <= 1'b0;
            ram_wen_q   <= 1'b0;
            addr_err_q  <= 1'b0;
`ifdef WRITER_READBACK_VERIFY_EN
            vfy_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            cur_data_q  <= cur_data_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_lohi_q  <= ram_lohi_d;
            ram_wen_q   <= ram_wen_d;
            addr_err_q  <= addr_err_d;
`ifdef WRITER_READBACK_VERIFY_EN
            vfy_err_q   <= vfy_err_d;
`endif
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_lohi  = ram_lohi_q;
    assign ram_wen   = ram_wen_q;
    assign addr_err  = addr_err_q;
    assign busy      = !fifo_empty || (state_q != IDLE);

`ifdef WRITER_READBACK_VERIFY_EN
    assign vfy_err = vfy_err_q;
    assign rb_addr = (state_q == VFY_LO || state_q == VFY_HI) ? cur_addr_q : '0;
    assign rb_lohi = (state_q == VFY_HI) ? ~LOHI_RD_LO : LOHI_RD_LO;
`endif

endmodule

// File: tb/tb_dffram_word_writer.sv
// Directed bench for dffram_word_writer with a nibble-write RAM model and write log.
module tb_dffram_word_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [4:0] in_addr = '0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic [4:0] ram_addr;
    logic [3:0] ram_wdata;
    logic       ram_lohi;
    logic       ram_wen;
    logic       busy;
    logic       addr_err;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [31:0] cyc = '0;

    logic [7:0] mem [32] = '{default: 8'h00};

    typedef struct packed {
        logic [31:0] stamp;
        logic [4:0]  addr;
        logic        lohi;
        logic [3:0]  nib;
    } wr_t;
    wr_t wlog[$];

    always #5 clk = ~clk;

`ifdef WRITER_READBACK_VERIFY_EN
    logic [4:0] rb_addr;
    logic       rb_lohi;
    logic [3:0] rb_rdata;
    logic       vfy_err;
    logic       corrupt = 1'b0;
    logic [7:0] rb_word;
    always_comb begin
        rb_word  = mem[rb_addr] ^ (corrupt ? 8'h40 : 8'h00);
        rb_rdata = rb_lohi ? rb_word[7:4] : rb_word[3:0];
    end
`endif

    dffram_word_writer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_lohi  (ram_lohi),
        .ram_wen   (ram_wen),
        .busy      (busy),
        .addr_err  (addr_err)
`ifdef WRITER_READBACK_VERIFY_EN
        ,
        .rb_addr   (rb_addr),
        .rb_lohi   (rb_lohi),
        .rb_rdata  (rb_rdata),
        .vfy_err   (vfy_err)
`endif
    );

    always @(posedge clk) begin
        cyc <= cyc + 32'd1;
        if (ram_wen) begin
            if (ram_lohi) mem[ram_addr][3:0] <= ram_wdata;
            else          mem[ram_addr][7:4] <= ram_wdata;
            wlog.push_back({cyc, ram_addr, ram_lohi, ram_wdata});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        while (busy && g < 60) begin
            step();
            g++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_idle_timeout busy=%b required 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        step();
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got %b required 0", in_ready); end
        n_cmp++;
        if ({ram_wen, ram_lohi, ram_wdata, ram_addr, busy, addr_err} !== 13'h0) begin
            n_bad++;
            $display("FAIL rst_outputs got %h required 0", {ram_wen, ram_lohi, ram_wdata, ram_addr, busy, addr_err});
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready got %b required 1", in_ready); end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_addr = 5'd3; in_data = 8'hA5;
        step();
        in_valid = 1'b0;
        n_cmp++;
        if ({ram_wen, busy} !== 2'b01) begin n_bad++; $display("FAIL single_accept wen,busy got %b required 01", {ram_wen, busy}); end
        step();
        n_cmp++;
        if ({ram_wen, ram_lohi, ram_wdata, ram_addr} !== {1'b1, 1'b1, 4'h5, 5'd3}) begin
            n_bad++;
            $display("FAIL single_lo got %h required %h", {ram_wen, ram_lohi, ram_wdata, ram_addr}, {1'b1, 1'b1, 4'h5, 5'd3});
        end
        step();
        n_cmp++;
        if ({ram_wen, ram_lohi, ram_wdata, ram_addr} !== {1'b1, 1'b0, 4'hA, 5'd3}) begin
            n_bad++;
            $display("FAIL single_hi got %h required %h", {ram_wen, ram_lohi, ram_wdata, ram_addr}, {1'b1, 1'b0, 4'hA, 5'd3});
        end
        step();
        n_cmp++;
        if ({ram_wen, busy} !== 2'b00) begin n_bad++; $display("FAIL single_done wen,busy got %b required 00", {ram_wen, busy}); end
        n_cmp++;
        if (mem[3] !== 8'hA5) begin n_bad++; $display("FAIL single_ram got %h required a5", mem[3]); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] a [5] = '{5'd20, 5'd21, 5'd22, 5'd23, 5'd24};
        logic [7:0] d [5] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
        int  base = wlog.size();
        int  k = 0;
        int  guard = 0;
        int  n;
        bit  saw_stall = 1'b0;
        bit  acc;
        wr_t e;
        logic [3:0] want_nib;
        while (k < 5 && guard < 40) begin
            in_valid = 1'b1; in_addr = a[k]; in_data = d[k];
            acc = in_ready;
            if (!acc) saw_stall = 1'b1;
            step();
            if (acc) k++;
            guard++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (k != 5) begin n_bad++; $display("FAIL b2b_accept_timeout accepted %0d required 5", k); end
        n_cmp++;
        if (!saw_stall) begin n_bad++; $display("FAIL b2b_ready_drop saw_stall=0 required 1"); end
        wait_idle("b2b");
        n = wlog.size() - base;
        n_cmp++;
        if (n != 10) begin n_bad++; $display("FAIL b2b_write_count got %0d required 10", n); end
        for (int i = 0; i < 10 && i < n; i++) begin
            e = wlog[base + i];
            want_nib = (i % 2 == 0) ? d[i/2][3:0] : d[i/2][7:4];
            n_cmp++;
            if (e.stamp !== wlog[base].stamp + 32'(i) || e.addr !== a[i/2] ||
                e.lohi !== (i % 2 == 0) || e.nib !== want_nib) begin
                n_bad++;
                $display("FAIL b2b_beat%0d got t=%0d a=%0d lohi=%b n=%h required t=%0d a=%0d lohi=%b n=%h",
                         i, e.stamp, e.addr, e.lohi, e.nib, wlog[base].stamp + 32'(i), a[i/2], (i % 2 == 0), want_nib);
            end
        end
        n_cmp++;
        if (mem[24] !== 8'h9A) begin n_bad++; $display("FAIL b2b_ram24 got %h required 9a", mem[24]); end
    endtask

    task automatic test_addr_err();
        int base = wlog.size();
        int hits = 0;
        in_valid = 1'b1; in_addr = 5'd28; in_data = 8'hFF;
        step();
        in_addr = 5'd1; in_data = 8'h3C;
        step();
        in_valid = 1'b0;
        n_cmp++;
        if ({addr_err, ram_wen} !== 2'b10) begin n_bad++; $display("FAIL aerr_drop err,wen got %b required 10", {addr_err, ram_wen}); end
        step();
        n_cmp++;
        if ({ram_wen, ram_lohi, ram_wdata, ram_addr} !== {1'b1, 1'b1, 4'hC, 5'd1}) begin
            n_bad++;
            $display("FAIL aerr_lo got %h required %h", {ram_wen, ram_lohi, ram_wdata, ram_addr}, {1'b1, 1'b1, 4'hC, 5'd1});
        end
        step();
        n_cmp++;
        if ({ram_wen, ram_lohi, ram_wdata, ram_addr} !== {1'b1, 1'b0, 4'h3, 5'd1}) begin
            n_bad++;
            $display("FAIL aerr_hi got %h required %h", {ram_wen, ram_lohi, ram_wdata, ram_addr}, {1'b1, 1'b0, 4'h3, 5'd1});
        end
        wait_idle("aerr");
        step();
        step();
        n_cmp++;
        if (addr_err !== 1'b1) begin n_bad++; $display("FAIL aerr_sticky got %b required 1", addr_err); end
        for (int i = base; i < wlog.size(); i++) if (wlog[i].addr == 5'd28) hits++;
        n_cmp++;
        if (hits != 0 || mem[28] !== 8'h00) begin
            n_bad++;
            $display("FAIL aerr_no_write writes=%0d ram28=%h required 0 and 00", hits, mem[28]);
        end
        n_cmp++;
        if (mem[1] !== 8'h3C) begin n_bad++; $display("FAIL aerr_ram1 got %h required 3c", mem[1]); end
    endtask

    task automatic test_reset_mid();
        int base = wlog.size();
        int hi_hits = 0;
        in_valid = 1'b1; in_addr = 5'd7; in_data = 8'hC3;
        step();
        in_valid = 1'b0;
        step();
        n_cmp++;
        if ({ram_wen, ram_lohi, ram_wdata, ram_addr} !== {1'b1, 1'b1, 4'h3, 5'd7}) begin
            n_bad++;
            $display("FAIL rmid_lo got %h required %h", {ram_wen, ram_lohi, ram_wdata, ram_addr}, {1'b1, 1'b1, 4'h3, 5'd7});
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if ({ram_wen, ram_lohi, ram_wdata, ram_addr, busy, addr_err, in_ready} !== 14'h0) begin
            n_bad++;
            $display("FAIL rmid_outputs got %h required 0", {ram_wen, ram_lohi, ram_wdata, ram_addr, busy, addr_err, in_ready});
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready got %b required 1", in_ready); end
        step();
        step();
        for (int i = base; i < wlog.size(); i++) if (wlog[i].addr == 5'd7 && wlog[i].lohi == 1'b0) hi_hits++;
        n_cmp++;
        if (hi_hits != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_no_hi hi_writes=%0d busy=%b required 0 and 0", hi_hits, busy);
        end
        n_cmp++;
        if (mem[7] !== 8'h03) begin n_bad++; $display("FAIL rmid_ram7 got %h required 03", mem[7]); end
    endtask

    task automatic test_same_edge();
        logic [4:0] a [3] = '{5'd4, 5'd5, 5'd6};
        logic [7:0] d [3] = '{8'hE1, 8'h2D, 8'h78};
        int  base = wlog.size();
        int  n;
        wr_t e;
        logic [3:0] want_nib;
        in_valid = 1'b1; in_addr = a[0]; in_data = d[0];
        step();
        in_addr = a[1]; in_data = d[1];
        step();
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL same_edge_occ1 in_ready got %b required 1", in_ready); end
        in_addr = a[2]; in_data = d[2];
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL same_edge_full in_ready got %b required 0", in_ready); end
        wait_idle("same_edge");
        n = wlog.size() - base;
        n_cmp++;
        if (n != 6) begin n_bad++; $display("FAIL same_edge_count got %0d required 6", n); end
        for (int i = 0; i < 6 && i < n; i++) begin
            e = wlog[base + i];
            want_nib = (i % 2 == 0) ? d[i/2][3:0] : d[i/2][7:4];
            n_cmp++;
            if (e.stamp !== wlog[base].stamp + 32'(i) || e.addr !== a[i/2] ||
                e.lohi !== (i % 2 == 0) || e.nib !== want_nib) begin
                n_bad++;
                $display("FAIL same_edge_beat%0d got a=%0d lohi=%b n=%h required a=%0d lohi=%b n=%h",
                         i, e.addr, e.lohi, e.nib, a[i/2], (i % 2 == 0), want_nib);
            end
        end
    endtask

`ifdef WRITER_READBACK_VERIFY_EN
    task automatic test_verify();
        corrupt = 1'b0;
        in_valid = 1'b1; in_addr = 5'd10; in_data = 8'h96;
        step();
        in_valid = 1'b0;
        wait_idle("vfy_clean");
        n_cmp++;
        if (vfy_err !== 1'b0 || mem[10] !== 8'h96) begin
            n_bad++;
            $display("FAIL vfy_clean vfy_err=%b ram10=%h required 0 and 96", vfy_err, mem[10]);
        end
        corrupt = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_idle("vfy_bad");
        n_cmp++;
        if (vfy_err !== 1'b1) begin n_bad++; $display("FAIL vfy_corrupt vfy_err got %b required 1", vfy_err); end
        corrupt = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
`ifdef WRITER_READBACK_VERIFY_EN
        test_verify();
`else
        test_single();
        test_back_to_back();
        test_addr_err();
        test_reset_mid();
        test_same_edge();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
